// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the instruction-fetch slice: datapath widths, the PC
// increment, the fetch FSM state encoding and the FIFO entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  // Byte distance between consecutive instruction words.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Mask that clears the byte offset inside a word.
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Small synchronous in-order FIFO holding fetched {pc, instruction} pairs.
// The head entry is read straight out of the storage registers, so the data
// seen by the consumer is always registered.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears pointers and storage)
//   push   in   write wdata at the tail
//   wdata  in   entry to write
//   pop    in   drop the head entry
//   flush  in   discard all entries; a push or pop in the same cycle is ignored
//   rdata  out  head entry (contents of the slot under the read pointer)
//   count  out  number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop: flush wins, pop needs data, push needs room.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_pop_s  = pop && (count_r != {CW{1'b0}});
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch initiator between decode and instruction memory. Holds the
// PC, issues word-aligned requests on a request/grant + response-valid bus,
// and buffers returned instructions with their PCs in an in-order FIFO.
// Jumps flush the buffer and discard responses to requests already granted.
//
// Configuration macro: IF_MISALIGN_CHK_EN
//   defined   : a jump to a non word-aligned target is ignored and misalign_o
//               pulses for one cycle (the cycle after the rejected jump).
//   undefined : the target's low two bits are cleared, misalign_o is tied 0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   inst_req_o      fetch request (credit-limited, only in FETCH)
//   inst_addr_o     fetch address (registered PC, always word aligned)
//   inst_gnt_i      memory accepts the request this cycle
//   inst_rvalid_i   in-order response valid, inst_i carries the instruction
//   if_valid_o      head instruction available to decode
//   if_inst_o       head instruction
//   if_pc_o         PC of the head instruction
//   id_ready_i      decode consumes the head when if_valid_o is high
//   jump_en_i       redirect request, jump_addr_i is the target
//   misalign_o      rejected misaligned redirect indication
// -----------------------------------------------------------------------------
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              inst_req_o,
  output logic [XLEN-1:0]   inst_addr_o,
  input  logic              inst_gnt_i,
  input  logic              inst_rvalid_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              if_valid_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic [XLEN-1:0]   if_pc_o,
  input  logic              id_ready_i,
  input  logic              jump_en_i,
  input  logic [XLEN-1:0]   jump_addr_i,
  output logic              misalign_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // counter width, holds 0..FIFO_DEPTH
  localparam int SW = CW + 1;                  // headroom for sums of two counters

  fetch_state_e      state_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   rsp_pc_r;
  logic [CW-1:0]     out_cnt_r;
  logic [CW-1:0]     discard_cnt_r;

  logic [CW-1:0]     fifo_cnt_s;
  fetch_entry_t      fifo_head_s;
  fetch_entry_t      fifo_wdata_s;
  logic              fifo_push_s;

  logic [XLEN-1:0]   jump_target_s;
  logic              jump_bad_s;
  logic              jump_req_s;
  logic              jump_take_s;
  logic              pop_s;
  logic              req_s;
  logic              grant_s;
  logic              rsp_s;
  logic [SW-1:0]     credit_sum_s;
  logic [SW-1:0]     stale_total_s;

  // Redirect qualification: misaligned targets are either rejected or forced.
`ifdef IF_MISALIGN_CHK_EN
  always_comb begin
    jump_bad_s = 1'b0;
    if (jump_en_i && (jump_addr_i[1:0] != 2'b00)) begin
      jump_bad_s = 1'b1;
    end else begin
      jump_bad_s = 1'b0;
    end
  end
`else
  assign jump_bad_s = 1'b0;
`endif

  assign jump_target_s = word_align(jump_addr_i);
  assign jump_req_s    = jump_en_i && !jump_bad_s;
  assign jump_take_s   = jump_req_s && (state_r != BOOT);
  assign rsp_s         = inst_rvalid_i;

  // Handshake decode: valid is masked by a redirect so a same-cycle pop is lost,
  // and the request is throttled so granted-but-unconsumed words fit the FIFO.
  always_comb begin
    if_valid_o    = 1'b0;
    pop_s         = 1'b0;
    req_s         = 1'b0;
    credit_sum_s  = {SW{1'b0}};
    stale_total_s = {SW{1'b0}};
    if ((fifo_cnt_s != {CW{1'b0}}) && !jump_req_s) begin
      if_valid_o = 1'b1;
    end else begin
      if_valid_o = 1'b0;
    end
    pop_s        = if_valid_o && id_ready_i;
    credit_sum_s = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_s} - SW'(pop_s);
    if (state_r == FETCH) begin
      req_s = (credit_sum_s < SW'(FIFO_DEPTH));
    end else begin
      req_s = 1'b0;
    end
    // Responses still owed by memory after this cycle; out_cnt_r is zero in
    // DRAIN and discard_cnt_r is zero in FETCH, so one sum covers both states.
    stale_total_s = {1'b0, out_cnt_r} + {1'b0, discard_cnt_r}
                  + SW'(req_s && inst_gnt_i) - SW'(rsp_s);
  end

  assign grant_s     = req_s && inst_gnt_i;
  assign inst_req_o  = req_s;
  assign inst_addr_o = pc_r;

  // Fetch FSM: PC, response PC, outstanding and discard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      out_cnt_r     <= {CW{1'b0}};
      discard_cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= FETCH;
        end
        FETCH: begin
          if (jump_take_s) begin
            pc_r          <= jump_target_s;
            rsp_pc_r      <= jump_target_s;
            out_cnt_r     <= {CW{1'b0}};
            discard_cnt_r <= stale_total_s[CW-1:0];
            state_r       <= (stale_total_s != {SW{1'b0}}) ? DRAIN : FETCH;
          end else begin
            if (grant_s) begin
              pc_r <= pc_r + PC_STEP;
            end
            if (rsp_s) begin
              rsp_pc_r <= rsp_pc_r + PC_STEP;
            end
            out_cnt_r <= out_cnt_r + CW'(grant_s) - CW'(rsp_s);
          end
        end
        DRAIN: begin
          if (jump_take_s) begin
            // Re-target but keep waiting for the stale responses still owed.
            pc_r          <= jump_target_s;
            rsp_pc_r      <= jump_target_s;
            discard_cnt_r <= stale_total_s[CW-1:0];
            state_r       <= (stale_total_s != {SW{1'b0}}) ? DRAIN : FETCH;
          end else if (rsp_s) begin
            discard_cnt_r <= discard_cnt_r - CW'(1'b1);
            if (discard_cnt_r == CW'(1'b1)) begin
              state_r <= FETCH;
            end
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

  // Responses are buffered only in FETCH and never in the redirect cycle.
  assign fifo_push_s       = rsp_s && (state_r == FETCH) && !jump_take_s;
  assign fifo_wdata_s.pc   = rsp_pc_r;
  assign fifo_wdata_s.inst = inst_i;

  if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .wdata (fifo_wdata_s),
    .pop   (pop_s),
    .flush (jump_take_s),
    .rdata (fifo_head_s),
    .count (fifo_cnt_s)
  );

  assign if_inst_o = fifo_head_s.inst;
  assign if_pc_o   = fifo_head_s.pc;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_r;

  // One-cycle flag for a redirect rejected because of its alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= jump_bad_s && (state_r != BOOT);
    end
  end

  assign misalign_o = misalign_r;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Randomised bench with a queue-based memory model and an in-order scoreboard.
// Honours IF_MISALIGN_CHK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        id_ready_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        misalign_o;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_req_o    (inst_req_o),
    .inst_addr_o   (inst_addr_o),
    .inst_gnt_i    (inst_gnt_i),
    .inst_rvalid_i (inst_rvalid_i),
    .inst_i        (inst_i),
    .if_valid_o    (if_valid_o),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .id_ready_i    (id_ready_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: every granted word, in grant order, tagged with the redirect
  // epoch it belongs to. Scoreboard: words decode must see, in order.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
  } mem_ent_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  mem_ent_t    mem_q[$];
  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cur_epoch = 0;
  logic [31:0] fetch_pc = RESET_PC;
  bit          boot = 1'b0;
  bit          exp_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed head is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && if_valid_o && id_ready_i) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h expected no instruction", if_pc_o);
        end else begin
          e = sb_q.pop_front();
          check("if_pc", if_pc_o, e.pc);
          check("if_inst", if_inst_o, e.inst);
        end
      end
    end
  end

  // One clock cycle of stimulus and model update; caller is at a falling edge.
  task automatic cycle_body(input int gnt_pct, input int rv_pct, input int rdy_pct,
                            input bit jmp, input logic [31:0] tgt);
    bit       rsp, jeff, pop, exp_valid, exp_req, grant;
    int       stale;
    mem_ent_t e;
    inst_gnt_i    = ($urandom_range(99) < gnt_pct);
    id_ready_i    = ($urandom_range(99) < rdy_pct);
    jump_en_i     = jmp;
    jump_addr_i   = tgt;
    rsp           = (mem_q.size() != 0) && ($urandom_range(99) < rv_pct);
    inst_rvalid_i = rsp;
    inst_i        = rsp ? mem_q[0].data : $urandom;
    #1;
    jeff = jmp && !boot;
`ifdef IF_MISALIGN_CHK_EN
    if (tgt[1:0] != 2'b00) jeff = 1'b0;
`endif
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != cur_epoch) stale++;
    exp_valid = (sb_q.size() != 0) && !jeff;
    pop       = exp_valid && id_ready_i;
    exp_req   = !boot && (stale == 0) &&
                (mem_q.size() + sb_q.size() - int'(pop) < DEPTH);
    check("if_valid", {31'd0, if_valid_o}, {31'd0, exp_valid});
    check("inst_req", {31'd0, inst_req_o}, {31'd0, exp_req});
    check("inst_addr", inst_addr_o, fetch_pc);
    check("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
    #2;
    grant = inst_req_o && inst_gnt_i;
    if (rsp) begin
      e = mem_q.pop_front();
      if ((e.epoch == cur_epoch) && !jeff) sb_q.push_back('{e.addr, e.data});
    end
    if (grant) begin
      e.addr  = fetch_pc;
      e.data  = $urandom;
      e.epoch = cur_epoch;
      mem_q.push_back(e);
      fetch_pc = fetch_pc + 32'd4;
    end
`ifdef IF_MISALIGN_CHK_EN
    exp_mis = jmp && !boot && (tgt[1:0] != 2'b00);
`else
    exp_mis = 1'b0;
`endif
    if (jeff) begin
      cur_epoch++;
      sb_q.delete();
      fetch_pc = tgt & 32'hFFFF_FFFC;
    end
    boot = 1'b0;
  endtask

  task automatic cycle(input int gnt_pct, input int rv_pct, input int rdy_pct,
                       input bit jmp, input logic [31:0] tgt);
    @(negedge clk);
    cycle_body(gnt_pct, rv_pct, rdy_pct, jmp, tgt);
  endtask

  // Reset (asserted mid-run too): outputs checked while held, then the BOOT cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inst_gnt_i = 1'b0; inst_rvalid_i = 1'b0; id_ready_i = 1'b0;
    jump_en_i = 1'b0; jump_addr_i = 32'd0; inst_i = 32'd0;
    mem_q.delete();
    sb_q.delete();
    cur_epoch++;
    fetch_pc = RESET_PC;
    exp_mis  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'd0, inst_req_o}, 32'd0);
    check("rst_addr", inst_addr_o, RESET_PC);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_inst", if_inst_o, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    boot  = 1'b1;
    cycle_body(100, 100, 100, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] tgt;
    int          waited;
    rst_n = 1'b0;
    do_reset();
    // Back-to-back stream with single-cycle memory.
    repeat (20) cycle(100, 100, 100, 1'b0, 32'd0);
    // Decode stalls: buffer fills and requests stop.
    repeat (10) cycle(100, 100, 0, 1'b0, 32'd0);
    check("stall_req_low", {31'd0, inst_req_o}, 32'd0);
    repeat (10) cycle(100, 100, 100, 1'b0, 32'd0);
    // Two outstanding, then jump to 0x100 while responses are still owed.
    repeat (2) cycle(100, 0, 100, 1'b0, 32'd0);
    cycle(100, 0, 100, 1'b1, 32'h0000_0100);
    repeat (10) cycle(100, 100, 100, 1'b0, 32'd0);
    // Jump coincident with a grant and a response.
    cycle(100, 100, 100, 1'b1, 32'h0000_0200);
    repeat (10) cycle(100, 100, 100, 1'b0, 32'd0);
    // Grant withheld: address must hold.
    repeat (5) cycle(0, 100, 100, 1'b0, 32'd0);
    repeat (6) cycle(100, 100, 100, 1'b0, 32'd0);
    // Misaligned target.
    cycle(100, 100, 100, 1'b1, 32'h0000_0102);
    repeat (10) cycle(100, 100, 100, 1'b0, 32'd0);
    // PC wrap-around.
    cycle(100, 100, 100, 1'b1, 32'hFFFF_FFF8);
    repeat (10) cycle(100, 100, 100, 1'b0, 32'd0);
    // Random traffic with random redirects.
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(60, 50, 70, ($urandom_range(99) < 3), tgt);
    end
    // Reset in the middle of traffic.
    do_reset();
    repeat (20) cycle(70, 60, 80, 1'b0, 32'd0);
    // Drain everything still owed, with a bounded wait.
    waited = 0;
    while ((mem_q.size() != 0 || sb_q.size() != 0) && waited < 50) begin
      cycle(0, 100, 100, 1'b0, 32'd0);
      waited++;
    end
    n_cmp++;
    if (mem_q.size() != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", mem_q.size() + sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch initiator sitting between the core's decode stage and instruction memory. Holds the PC, issues word-aligned fetch requests over a request/grant plus response-valid interface, and buffers returned instructions with their PCs in a small in-order FIFO. Handles jump redirects by flushing buffered and in-flight fetches. Replaces direct combinational instruction-address/instruction wiring once memory latency becomes non-zero.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2; also caps outstanding requests
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_req_o  out  1  fetch request
- inst_addr_o  out  32  fetch address, bits [1:0] always 0
- inst_gnt_i  in  1  memory accepts request this cycle
- inst_rvalid_i  in  1  response valid; in order, ≥1 cycle after its grant
- inst_i  in  32  returned instruction
- if_valid_o  out  1  instruction available to decode
- if_inst_o  out  32  instruction at FIFO head
- if_pc_o  out  32  PC of that instruction
- id_ready_i  in  1  decode consumes head when if_valid_o=1
- jump_en_i  in  1  redirect request
- jump_addr_i  in  32  redirect target
- misalign_o  out  1  one-cycle pulse on rejected misaligned redirect

## Operation
- States: BOOT, FETCH, DRAIN. Reset → BOOT; BOOT → FETCH unconditionally next cycle.
- Credit: inst_req_o = (state==FETCH) && (out_cnt + fifo_cnt − pop < FIFO_DEPTH), pop = if_valid_o && id_ready_i.
- Grant (inst_req_o && inst_gnt_i): out_cnt++, pc += 4 (wraps modulo 2^32).
- inst_addr_o = pc; stable while inst_req_o high without grant. Memory tolerates request withdrawal without grant.
- Response in FETCH: push {rsp_pc, inst_i}, rsp_pc += 4, out_cnt−−. Credit rule guarantees FIFO never overflows.
- Simultaneous grant and response: out_cnt unchanged.
- Redirect (jump_en_i, accepted in any state except BOOT):
  - FIFO cleared; pc and rsp_pc ← jump_addr_i.
  - discard_cnt ← out_cnt, plus 1 if granted this cycle, minus 1 if response this cycle. A same-cycle response is dropped.
  - Next state is DRAIN if discard_cnt > 0, else FETCH.
- DRAIN: no requests; each response is dropped and decrements discard_cnt; DRAIN → FETCH when it reaches 0. A new redirect in DRAIN re-targets pc and keeps counting remaining stale responses.
- if_valid_o = (fifo_cnt ≠ 0) && !jump_en_i. A pop in a redirect cycle is ignored.
- Reset values: inst_req_o 0, inst_addr_o RESET_PC, if_valid_o 0, if_inst_o 0, if_pc_o 0, misalign_o 0, out_cnt/fifo_cnt/discard_cnt 0.
- Reset mid-operation clears all state. Responses to pre-reset grants are the memory's responsibility to suppress.

## Timing
- First inst_req_o in the 2nd rising edge after rst_n release (BOOT lasts 1 cycle).
- Fetch latency: grant in cycle N, response in N+1 → if_valid_o in N+2. FIFO is registered; no response-to-decode bypass.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory latency, FIFO_DEPTH=2, id_ready_i held high.
- First post-redirect request: the cycle after jump_en_i if nothing is outstanding; otherwise the cycle after the last stale response.

## Configuration
- IF_MISALIGN_CHK_EN defined:
  - jump_addr_i[1:0] ≠ 0 → redirect ignored entirely (no flush, pc unchanged).
  - misalign_o pulses 1 cycle.
- Undefined: jump_addr_i[1:0] forced to 0, redirect proceeds normally, misalign_o tied 0.

## Structure
- Shared package (rv_pkg): XLEN=32, INST_W=32, PC_STEP=4, fetch FSM state enum {BOOT, FETCH, DRAIN}.
- Sub-module if_fifo: parameterised sync FIFO (width 64, depth FIFO_DEPTH) with push, pop, flush, count.

## Test plan
- Reset release, RESET_PC=0, gnt always 1, rvalid 1 cycle later, id_ready 1 → inst_req_o at 2nd edge; addrs 0,4,8,…; if_pc_o 0,4,8 on consecutive cycles from cycle 4.
- id_ready_i=0 for 10 cycles → at most FIFO_DEPTH grants outstanding+buffered, inst_req_o drops, no lost or duplicated PCs after release.
- Two requests outstanding, jump_en_i to 32'h100 → if_valid_o low that cycle, DRAIN; both stale responses dropped; next if_pc_o = 32'h100.
- Redirect coincident with grant and response → discard_cnt accounting correct, no stale instruction reaches decode.
- inst_gnt_i held low 5 cycles → inst_addr_o stable, no pc advance.
- With IF_MISALIGN_CHK_EN: jump_addr_i=32'h102 → misalign_o 1-cycle pulse, fetch stream continues uninterrupted; without the macro, fetch resumes at 32'h100.
